// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the execute payload, waits for load data,
// aligns/extends it and tracks responses orphaned by a flush.
module mem_stage #(
    parameter int SB_W = 128
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 EM_valid,
    output logic                 M_allowin,
    input  logic [75+SB_W-1:0]   EM_BUS,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    output logic                 drop_pending,
    input  logic                 W_allowin,
    output logic                 MW_valid,
    output logic [71+SB_W-1:0]   MW_BUS,
    output logic [37:0]          M_fwd,
    output logic                 M_ld_busy
);

    localparam int EMW = 75 + SB_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic            m_valid;
    logic [EMW-1:0]  em_q;
    logic [31:0]     rbuf;
    logic            rbuf_vld;

    logic            ex;
    logic [2:0]      ld_type;
    logic            mem_rd;
    logic [4:0]      dest;
    logic            gr_we;
    logic [31:0]     alu_result;
    logic [31:0]     pc;
    logic [SB_W-1:0] sb;

    assign ex         = em_q[0];
    assign ld_type    = em_q[3:1];
    assign mem_rd     = em_q[4];
    assign dest       = em_q[9:5];
    assign gr_we      = em_q[10];
    assign alu_result = em_q[42:11];
    assign pc         = em_q[74:43];
    assign sb         = em_q[EMW-1:75];

    logic resp;
    logic ready_go;
    logic accept;
    logic leave;
    logic ld_acc;

    // data_ok outside WAIT belongs to no held load
    assign resp      = data_sram_data_ok && (state == S_WAIT);
    assign ready_go  = !mem_rd || resp || rbuf_vld;
    assign MW_valid  = m_valid && ready_go;
    assign M_allowin = (!m_valid || (ready_go && W_allowin))
                       && (state != S_DROP);
    assign accept    = EM_valid && M_allowin;
    assign leave     = MW_valid && W_allowin;
    assign ld_acc    = accept && EM_BUS[4];

    always_comb begin
        state_nxt = state;
        if (flush) begin
            case (state)
                S_DROP:  state_nxt = S_DROP;
                S_WAIT:  state_nxt = data_sram_data_ok ? S_IDLE : S_DROP;
                default: state_nxt = S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (ld_acc) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (ld_acc)
                        state_nxt = S_WAIT;
                    else if (data_sram_data_ok)
                        state_nxt = S_IDLE;
                end
                S_DROP: begin
                    if (data_sram_data_ok) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            m_valid <= 1'b0;
            em_q    <= '0;
        end else begin
            if (M_allowin) m_valid <= EM_valid;
            if (accept)    em_q    <= EM_BUS;
        end
    end

    // hold returned data while writeback stalls; data_ok will not repeat
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            rbuf_vld <= 1'b0;
            rbuf     <= '0;
        end else if (leave) begin
            rbuf_vld <= 1'b0;
        end else if (resp && m_valid && !W_allowin) begin
            rbuf_vld <= 1'b1;
            rbuf     <= data_sram_rdata;
        end
    end

    logic [31:0] ld_data;
    logic [4:0]  bsh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_val;
    logic        is_b;
    logic        is_bu;
    logic        is_h;
    logic        is_hu;

    assign ld_data  = rbuf_vld ? rbuf : data_sram_rdata;
    assign bsh      = {alu_result[1:0], 3'b000};
    assign byte_sel = ld_data[bsh +: 8];
    assign half_sel = alu_result[1] ? ld_data[31:16] : ld_data[15:0];

    assign is_b  = (ld_type == 3'b001);
    assign is_bu = (ld_type == 3'b101);
    assign is_h  = (ld_type == 3'b010);
    assign is_hu = (ld_type == 3'b110);

    always_comb begin
        ld_val = ld_data;
        unique case (1'b1)
            is_b:    ld_val = {{24{byte_sel[7]}}, byte_sel};
            is_bu:   ld_val = {24'h0, byte_sel};
            is_h:    ld_val = {{16{half_sel[15]}}, half_sel};
            is_hu:   ld_val = {16'h0, half_sel};
            default: ld_val = ld_data;
        endcase
    end

    logic [31:0] final_result;
    logic        fwd_we;

    assign final_result = mem_rd ? ld_val : alu_result;
    assign fwd_we       = m_valid && gr_we && !ex && ready_go;

    assign MW_BUS       = {sb, pc, final_result, gr_we, dest, ex};
    assign M_fwd        = {fwd_we, dest, final_result};
    assign M_ld_busy    = m_valid && mem_rd && !ready_go;
    assign drop_pending = (state == S_DROP);

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load extraction, stalls,
// response buffering, flush/drop handling and back-to-back ALU flow.
module tb_mem_stage;

    localparam int SB_W = 128;
    localparam int EMW  = 75 + SB_W;
    localparam int MWW  = 71 + SB_W;

    logic            clk;
    logic            rstn;
    logic            flush;
    logic            EM_valid;
    logic            M_allowin;
    logic [EMW-1:0]  EM_BUS;
    logic            data_sram_data_ok;
    logic [31:0]     data_sram_rdata;
    logic            drop_pending;
    logic            W_allowin;
    logic            MW_valid;
    logic [MWW-1:0]  MW_BUS;
    logic [37:0]     M_fwd;
    logic            M_ld_busy;

    int errors;
    int checks;

    logic [31:0] mw_res;
    logic        fwd_we;

    assign mw_res = MW_BUS[38:7];
    assign fwd_we = M_fwd[37];

    mem_stage #(.SB_W(SB_W)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .flush             (flush),
        .EM_valid          (EM_valid),
        .M_allowin         (M_allowin),
        .EM_BUS            (EM_BUS),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .drop_pending      (drop_pending),
        .W_allowin         (W_allowin),
        .MW_valid          (MW_valid),
        .MW_BUS            (MW_BUS),
        .M_fwd             (M_fwd),
        .M_ld_busy         (M_ld_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SB_W-1:0] sbv(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'h5A5A_5A5A, 32'h0123_4567};
    endfunction

    function automatic logic [EMW-1:0] em(input logic [31:0] pc,
                                          input logic [31:0] alu,
                                          input logic        rd,
                                          input logic [2:0]  lt);
        return {sbv(pc), pc, alu, 1'b1, 5'd7, rd, lt, 1'b0};
    endfunction

    function automatic logic [MWW-1:0] mw(input logic [31:0] pc,
                                          input logic [31:0] fin);
        return {sbv(pc), pc, fin, 1'b1, 5'd7, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [EMW-1:0] bus);
        EM_valid = 1'b1;
        EM_BUS   = bus;
        tick();
        EM_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (MW_valid !== 1'b0) begin errors++; $display("FAIL rst_mw_valid got %b want 0", MW_valid); end
        checks++; if (M_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got %b want 1", M_allowin); end
        checks++; if (drop_pending !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", drop_pending); end
        checks++; if (M_ld_busy !== 1'b0) begin errors++; $display("FAIL rst_ld_busy got %b want 0", M_ld_busy); end
        checks++; if (M_fwd !== 38'h0) begin errors++; $display("FAIL rst_fwd got %h want 0", M_fwd); end
        checks++; if (MW_BUS !== '0) begin errors++; $display("FAIL rst_mw_bus got %h want 0", MW_BUS); end
        rstn = 1'b1;
    endtask

    task automatic test_ld_byte();
        logic [2:0]  lt  [2];
        logic [31:0] exp [2];
        lt[0] = 3'b001; exp[0] = 32'hFFFF_FF80;
        lt[1] = 3'b101; exp[1] = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            issue(em(32'h1C00_0100 + i, 32'h0000_1003, 1'b1, lt[i]));
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'h80FF_1234;
            #1;
            checks++; if (MW_valid !== 1'b1) begin errors++; $display("FAIL ldb_mw_valid[%0d] got %b want 1", i, MW_valid); end
            checks++; if (mw_res !== exp[i]) begin errors++; $display("FAIL ldb_result[%0d] got %h want %h", i, mw_res, exp[i]); end
            checks++; if (M_fwd[31:0] !== exp[i]) begin errors++; $display("FAIL ldb_fwd[%0d] got %h want %h", i, M_fwd[31:0], exp[i]); end
            tick();
            data_sram_data_ok = 1'b0;
        end
    endtask

    task automatic test_ld_half();
        logic [2:0]  lt  [3];
        logic [31:0] exp [3];
        lt[0] = 3'b010; exp[0] = 32'hFFFF_8001;
        lt[1] = 3'b110; exp[1] = 32'h0000_8001;
        lt[2] = 3'b000; exp[2] = 32'h8001_ABCD;
        for (int i = 0; i < 3; i++) begin
            issue(em(32'h1C00_0200 + i, 32'h0000_2002, 1'b1, lt[i]));
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'h8001_ABCD;
            #1;
            checks++; if (MW_valid !== 1'b1) begin errors++; $display("FAIL ldh_mw_valid[%0d] got %b want 1", i, MW_valid); end
            checks++; if (mw_res !== exp[i]) begin errors++; $display("FAIL ldh_result[%0d] got %h want %h", i, mw_res, exp[i]); end
            tick();
            data_sram_data_ok = 1'b0;
        end
    endtask

    task automatic test_late_load();
        issue(em(32'h1C00_0300, 32'h0000_3000, 1'b1, 3'b000));
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (MW_valid !== 1'b0) begin errors++; $display("FAIL late_mw_valid[%0d] got %b want 0", i, MW_valid); end
            checks++; if (M_allowin !== 1'b0) begin errors++; $display("FAIL late_allowin[%0d] got %b want 0", i, M_allowin); end
            checks++; if (M_ld_busy !== 1'b1) begin errors++; $display("FAIL late_ld_busy[%0d] got %b want 1", i, M_ld_busy); end
            checks++; if (fwd_we !== 1'b0) begin errors++; $display("FAIL late_fwd_we[%0d] got %b want 0", i, fwd_we); end
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        checks++; if (MW_valid !== 1'b1) begin errors++; $display("FAIL late_ok_mw_valid got %b want 1", MW_valid); end
        checks++; if (fwd_we !== 1'b1) begin errors++; $display("FAIL late_ok_fwd_we got %b want 1", fwd_we); end
        checks++; if (mw_res !== 32'hCAFE_F00D) begin errors++; $display("FAIL late_ok_result got %h want cafef00d", mw_res); end
        checks++; if (M_ld_busy !== 1'b0) begin errors++; $display("FAIL late_ok_ld_busy got %b want 0", M_ld_busy); end
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_rbuf();
        issue(em(32'h1C00_0400, 32'h0000_4000, 1'b1, 3'b000));
        W_allowin         = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        #1;
        checks++; if (MW_valid !== 1'b1) begin errors++; $display("FAIL rbuf_t0_mw_valid got %b want 1", MW_valid); end
        checks++; if (M_allowin !== 1'b0) begin errors++; $display("FAIL rbuf_t0_allowin got %b want 0", M_allowin); end
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        checks++; if (dut.rbuf_vld !== 1'b1) begin errors++; $display("FAIL rbuf_vld got %b want 1", dut.rbuf_vld); end
        checks++; if (mw_res !== 32'h1234_5678) begin errors++; $display("FAIL rbuf_t1_result got %h want 12345678", mw_res); end
        checks++; if (MW_valid !== 1'b1) begin errors++; $display("FAIL rbuf_t1_mw_valid got %b want 1", MW_valid); end
        tick();
        W_allowin = 1'b1;
        EM_valid  = 1'b1;
        EM_BUS    = em(32'h1C00_0404, 32'h0000_5555, 1'b0, 3'b000);
        #1;
        checks++; if (MW_BUS !== mw(32'h1C00_0400, 32'h1234_5678)) begin errors++; $display("FAIL rbuf_t2_bus got %h want %h", MW_BUS, mw(32'h1C00_0400, 32'h1234_5678)); end
        checks++; if (M_allowin !== 1'b1) begin errors++; $display("FAIL rbuf_t2_allowin got %b want 1", M_allowin); end
        tick();
        EM_valid = 1'b0;
        #1;
        checks++; if (mw_res !== 32'h0000_5555) begin errors++; $display("FAIL rbuf_next_result got %h want 00005555", mw_res); end
        checks++; if (dut.rbuf_vld !== 1'b0) begin errors++; $display("FAIL rbuf_vld_clr got %b want 0", dut.rbuf_vld); end
        tick();
    endtask

    task automatic test_flush_drop();
        int seen;
        seen = 0;
        issue(em(32'h1C00_0500, 32'h0000_6000, 1'b1, 3'b000));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        seen += int'(MW_valid);
        checks++; if (drop_pending !== 1'b1) begin errors++; $display("FAIL drop_t1_pending got %b want 1", drop_pending); end
        checks++; if (M_allowin !== 1'b0) begin errors++; $display("FAIL drop_t1_allowin got %b want 0", M_allowin); end
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_0BAD;
        #1;
        seen += int'(MW_valid);
        checks++; if (drop_pending !== 1'b1) begin errors++; $display("FAIL drop_t2_pending got %b want 1", drop_pending); end
        checks++; if (M_allowin !== 1'b0) begin errors++; $display("FAIL drop_t2_allowin got %b want 0", M_allowin); end
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        seen += int'(MW_valid);
        checks++; if (drop_pending !== 1'b0) begin errors++; $display("FAIL drop_end_pending got %b want 0", drop_pending); end
        checks++; if (M_allowin !== 1'b1) begin errors++; $display("FAIL drop_end_allowin got %b want 1", M_allowin); end
        checks++; if (seen !== 0) begin errors++; $display("FAIL drop_mw_valid_seen got %0d want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int stalls;
        stalls = 0;
        for (int i = 1; i <= 3; i++) begin
            EM_valid = 1'b1;
            EM_BUS   = em(32'h1C00_0600 + 4 * i, i, 1'b0, 3'b000);
            #1;
            stalls += int'(!M_allowin);
            tick();
            checks++; if (MW_valid !== 1'b1) begin errors++; $display("FAIL b2b_mw_valid[%0d] got %b want 1", i, MW_valid); end
            checks++; if (MW_BUS !== mw(32'h1C00_0600 + 4 * i, i)) begin errors++; $display("FAIL b2b_bus[%0d] got %h want %h", i, MW_BUS, mw(32'h1C00_0600 + 4 * i, i)); end
        end
        EM_valid = 1'b0;
        #1;
        stalls += int'(!M_allowin);
        checks++; if (stalls !== 0) begin errors++; $display("FAIL b2b_allowin_drops got %0d want 0", stalls); end
        tick();
        checks++; if (MW_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", MW_valid); end
    endtask

    task automatic test_flush_coincident();
        issue(em(32'h1C00_0700, 32'h0000_0077, 1'b0, 3'b000));
        EM_valid = 1'b1;
        EM_BUS   = em(32'h1C00_0704, 32'h0000_0078, 1'b0, 3'b000);
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        EM_valid = 1'b0;
        #1;
        checks++; if (MW_valid !== 1'b0) begin errors++; $display("FAIL fl_coinc_mw_valid got %b want 0", MW_valid); end
        checks++; if (MW_BUS !== '0) begin errors++; $display("FAIL fl_coinc_bus got %h want 0", MW_BUS); end
    endtask

    task automatic test_reset_mid_wait();
        issue(em(32'h1C00_0800, 32'h0000_8000, 1'b1, 3'b000));
        #1;
        checks++; if (M_ld_busy !== 1'b1) begin errors++; $display("FAIL rstw_pre_busy got %b want 1", M_ld_busy); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        checks++; if (M_ld_busy !== 1'b0) begin errors++; $display("FAIL rstw_busy got %b want 0", M_ld_busy); end
        checks++; if (M_allowin !== 1'b1) begin errors++; $display("FAIL rstw_allowin got %b want 1", M_allowin); end
        checks++; if (drop_pending !== 1'b0) begin errors++; $display("FAIL rstw_drop got %b want 0", drop_pending); end
        checks++; if (MW_valid !== 1'b0) begin errors++; $display("FAIL rstw_mw_valid got %b want 0", MW_valid); end
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        rstn              = 1'b0;
        flush             = 1'b0;
        EM_valid          = 1'b0;
        EM_BUS            = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        W_allowin         = 1'b1;
        test_reset();
        tick();
        test_ld_byte();
        test_ld_half();
        test_late_load();
        test_rbuf();
        test_flush_drop();
        test_back_to_back();
        test_flush_coincident();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the 5-stage CPU: sits between execute and writeback. It accepts the execute payload on a valid/allowin handshake and waits for the data-SRAM response of any load issued in execute. It then aligns and sign/zero-extends the load data and presents the result bus to writeback. It also owns the bookkeeping for load responses orphaned by an exception flush.

## Interface
- SB_W, 128, width of sideband bits (CSR/TLB/exception fields) carried unchanged from EM_BUS to MW_BUS

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  exception/ertn flush from CSR unit; kills the stage content
- EM_valid  in  1  execute stage holds a valid instruction
- M_allowin  out  1  stage can accept EM_BUS this cycle
- EM_BUS  in  75+SB_W  {sb[SB_W], pc[32], alu_result[32], gr_we, dest[5], mem_rd, ld_type[3], ex}, MSB first
- data_sram_data_ok  in  1  load response strobe, in-order, one per accepted request
- data_sram_rdata  in  32  load response word
- drop_pending  out  1  an orphaned response is outstanding; execute must not issue data requests
- W_allowin  in  1  writeback can accept
- MW_valid  out  1  MW_BUS valid to writeback
- MW_BUS  out  71+SB_W  {sb, pc, final_result[32], gr_we, dest, ex}
- M_fwd  out  38  {fwd_we, dest[5], result[32]} bypass to decode
- M_ld_busy  out  1  stage holds a load whose data has not yet returned (decode stalls on load-use)

## Operation
- mem_rd=1 means execute's request was accepted by the SRAM. mem_rd is never set together with ex=1.
- ld_type: 000 ld.w, 001 ld.b, 010 ld.h, 101 ld.bu, 110 ld.hu. Other codes behave as ld.w.
- Byte offset = alu_result[1:0]. ld.b/bu select byte rdata[8*off+7:8*off]. ld.h/hu select half rdata[16*off[1]+15:16*off[1]]. Signed types sign-extend to 32 bits, unsigned types zero-extend.
- final_result is the extracted load value when mem_rd=1, otherwise alu_result.
- FSM states:
  - IDLE: no response expected.
  - WAIT: the held load awaits data_ok.
  - DROP: a flushed load's data_ok is still outstanding.
- FSM transitions:
  - IDLE→WAIT when an instruction with mem_rd=1 is latched.
  - WAIT→IDLE on data_ok.
  - WAIT→DROP on flush without data_ok in the same cycle.
  - DROP→IDLE on data_ok; that data is discarded.
- Response buffer: if data_ok arrives while the stage is valid and W_allowin=0, capture rdata into rbuf and set rbuf_vld. rbuf_vld clears when the instruction leaves or on flush. Extraction uses rbuf when rbuf_vld=1.
- M_ready_go = !mem_rd || data_ok || rbuf_vld.
- MW_valid = M_valid && M_ready_go.
- M_allowin = (!M_valid || (M_ready_go && W_allowin)) && state!=DROP.
- Stage regs load EM_BUS when EM_valid && M_allowin. M_valid <= EM_valid whenever M_allowin=1.
- drop_pending = (state==DROP).
- M_ld_busy = M_valid && mem_rd && !M_ready_go.
- fwd_we = M_valid && gr_we && !ex && M_ready_go. M_fwd.result = final_result.

## Timing
- Reset state: M_valid=0, stage regs=0, state=IDLE, rbuf_vld=0.
- Outputs under reset: MW_valid=0, M_allowin=1, drop_pending=0, M_ld_busy=0, M_fwd=0.
- Non-load instructions: one cycle in stage. MW_valid rises in the cycle after acceptance.
- Loads: MW_valid is asserted in the same cycle as data_ok (combinational path rdata→MW_BUS), earliest the first cycle in stage.
- The writeback transfer occurs on MW_valid && W_allowin. Content on MW_BUS is stable while MW_valid && !W_allowin.
- Flush has priority over everything else. In the next cycle: M_valid=0, stage regs=0, rbuf_vld=0. A coincident EM_valid is ignored.
- Flush while in DROP: remain in DROP.
- Flush in IDLE, or in WAIT with coincident data_ok: go to IDLE.
- data_ok in IDLE is a protocol violation and is ignored.
- Reset mid-WAIT/DROP returns to IDLE. The memory subsystem is reset at the same time.

## Test plan
- ld.b, alu_result=0x1003, rdata=0x80FF1234 with same-cycle data_ok → final_result=0xFFFFFF80, MW_valid=1 that cycle. The same access as ld.bu → 0x00000080.
- ld.h, offset 2, rdata=0x8001ABCD → 0xFFFF8001. ld.hu → 0x00008001. ld.w → 0x8001ABCD.
- ld.w with data_ok 3 cycles late → during the wait: MW_valid=0, M_allowin=0, M_ld_busy=1, fwd_we=0. In the data_ok cycle: MW_valid=1, fwd_we=1.
- W_allowin=0 when data_ok (rdata=0x12345678) arrives → rbuf_vld=1. Two cycles later W_allowin=1 → MW_BUS.final_result=0x12345678 with no new data_ok. The next instruction is accepted that cycle.
- Flush in WAIT, data_ok 2 cycles later → drop_pending=1 and M_allowin=0 until data_ok, MW_valid never 1, state IDLE after.
- Back-to-back ALU ops (alu_result 0x1, 0x2, 0x3), W_allowin=1 → one MW transfer per cycle, final_result equals alu_result, M_allowin constantly 1.
